calc_sequencer: RTL and testbench

Sequencing controller for the keypad calculator datapath. It sits between the keypad scanner's `key`/`key_valid` strobe and the arithmetic datapath. Key strobes are assembled into operand A, an operator and operand B; on the equals key the operation is launched. Add, subtract, divide and multiply complete in one cycle. Power runs iteratively, one multiply per cycle, so no combinational loop is needed. Status and the result are reported through registered outputs.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/pow_iter.sv | 56 +++++
 rtl/calc_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and key codes for the keypad calculator sequencer and its power unit.
package calc_pkg;

  localparam int DEFAULT_DW = 8;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_DIV = 4'hC;
  localparam logic [3:0] KEY_MUL = 4'hD;
  localparam logic [3:0] KEY_POW = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  // Opcode encodings equal the operator key codes so the latched opcode drives op_display directly.
  typedef enum logic [3:0] {
    OP_NONE = 4'h0,
    OP_ADD  = 4'hA,
    OP_SUB  = 4'hB,
    OP_DIV  = 4'hC,
    OP_MUL  = 4'hD,
    OP_POW  = 4'hE
  } opcode_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'h9;
  endfunction

  function automatic logic is_operator(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_POW);
  endfunction

endpackage

// File: rtl/pow_iter.sv
// Iterative power unit: one truncated multiply per enabled cycle, with a sticky overflow flag.
module pow_iter
  import calc_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          en,
  input  logic [DW-1:0] base,
  input  logic [DW-1:0] exp,
  output logic          done,
  output logic [DW-1:0] acc,
  output logic          ovf
);

  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [2*DW-1:0] prod;

  assign prod = {{DW{1'b0}}, acc_q} * {{DW{1'b0}}, base};

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (start) begin
      acc_d = DW'(1);
      cnt_d = exp;
      ovf_d = 1'b0;
    end else if (en && (cnt_q != '0)) begin
      acc_d = prod[DW-1:0];
      cnt_d = cnt_q - DW'(1);
      ovf_d = ovf_q | (|prod[2*DW-1:DW]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign done = (cnt_q == '0);
  assign acc  = acc_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: assembles A/op/B from key strobes and launches the operation.
// Define CALC_CHAIN_EN to let an operator key in S_DONE chain on the previous result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    key,
  input  logic          key_valid,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          busy,
  output logic          ovf,
  output logic          err,
  output logic [3:0]    op_display
);

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  opcode_t         op_q, op_d;
  logic            b_seen_q, b_seen_d;
  logic [DW-1:0]   result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic            key_digit, key_op, key_eq;
  logic [DW:0]     sum;
  logic [2*DW-1:0] prod;
  logic            pow_start, pow_en, pow_done, pow_ovf;
  logic [DW-1:0]   pow_acc;

  assign key_digit = key_valid && is_digit(key);
  assign key_op    = key_valid && is_operator(key);
  assign key_eq    = key_valid && (key == KEY_EQ);

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign prod = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};

  assign pow_en = (state_q == S_CALC) && (op_q == OP_POW);

  pow_iter #(.DW(DW)) u_pow (
    .clk   (clk),
    .reset (reset),
    .start (pow_start),
    .en    (pow_en),
    .base  (a_q),
    .exp   (b_q),
    .done  (pow_done),
    .acc   (pow_acc),
    .ovf   (pow_ovf)
  );

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    b_seen_d       = b_seen_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    ovf_d          = ovf_q;
    err_d          = err_q;
    pow_start      = 1'b0;

    case (state_q)
      S_A: begin
        if (key_digit) begin
          a_d     = DW'(key);
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (key_digit) begin
          a_d = DW'(key);
        end else if (key_op) begin
          op_d     = opcode_t'(key);
          b_seen_d = 1'b0;
          state_d  = S_B;
        end else if (key_eq) begin
          op_d    = OP_NONE;
          state_d = S_A;
        end
      end
      S_B: begin
        if (key_digit) begin
          b_d      = DW'(key);
          b_seen_d = 1'b1;
        end else if (key_op) begin
          op_d = opcode_t'(key);
        end else if (key_eq && b_seen_q) begin
          pow_start = (op_q == OP_POW);
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        // Keys are deliberately ignored here, including on the final cycle.
        result_valid_d = 1'b1;
        err_d          = 1'b0;
        state_d        = S_DONE;
        case (op_q)
          OP_ADD: begin
            result_d = sum[DW-1:0];
            ovf_d    = sum[DW];
          end
          OP_SUB: begin
            result_d = a_q - b_q;
            ovf_d    = (a_q < b_q);
          end
          OP_MUL: begin
            result_d = prod[DW-1:0];
            ovf_d    = |prod[2*DW-1:DW];
          end
          OP_DIV: begin
            ovf_d = 1'b0;
            if (b_q == '0) begin
              result_d = '1;
              err_d    = 1'b1;
            end else begin
              result_d = a_q / b_q;
            end
          end
          OP_POW: begin
            if (pow_done) begin
              result_d = pow_acc;
              ovf_d    = pow_ovf;
            end else begin
              result_valid_d = 1'b0;
              err_d          = err_q;
              state_d        = S_CALC;
            end
          end
          default: begin
            result_valid_d = 1'b0;
            err_d          = err_q;
            state_d        = S_A;
          end
        endcase
      end
      S_DONE: begin
        if (key_digit) begin
          a_d     = DW'(key);
          state_d = S_OP;
        end else if (key_eq) begin
          op_d    = OP_NONE;
          state_d = S_A;
        end
`ifdef CALC_CHAIN_EN
        else if (key_op) begin
          a_d      = result_q;
          op_d     = opcode_t'(key);
          b_seen_d = 1'b0;
          state_d  = S_B;
        end
`endif
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_A;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= OP_NONE;
      b_seen_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      b_seen_q       <= b_seen_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      err_q          <= err_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q == S_CALC);
  assign ovf          = ovf_q;
  assign err          = err_q;
  assign op_display   = op_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with hand-computed expected results.
module tb_calc_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    key = 4'h0;
  logic          key_valid = 1'b0;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          busy;
  logic          ovf;
  logic          err;
  logic [3:0]    op_display;

  int errors = 0;
  int checks = 0;

  calc_sequencer #(.DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .key_valid    (key_valid),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .ovf          (ovf),
    .err          (err),
    .op_display   (op_display)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Drives one key strobe; returns at the falling edge right after the sampling edge.
  task automatic press(input logic [3:0] k);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press_seq(input logic [3:0] k0, input logic [3:0] k1,
                           input logic [3:0] k2, input logic [3:0] k3);
    press(k0);
    press(k1);
    press(k2);
    press(k3);
  endtask

  // Counts falling edges until result_valid, and how many of them saw busy.
  task automatic wait_result(input int max, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!result_valid && lat < max) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!result_valid) begin
      lat = -1;
    end
  endtask

  // Watches n falling edges and reports whether result_valid was ever seen.
  task automatic watch_quiet(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
  endtask

  initial begin
    int lat, bc, seen;

    @(negedge clk);
    @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_outputs", {result_valid, busy, ovf, err, op_display}, 0);
    reset = 1'b0;
    @(negedge clk);

    // 3 * 4
    press(4'h3);
    press(4'hD);
    check("mul_op_display", int'(op_display), 4'hD);
    press(4'h4);
    press(4'hF);
    check("mul_busy_after_eq", int'(busy), 1);
    wait_result(20, lat, bc);
    check("mul_latency", lat, 1);
    check("mul_result", int'(result), 12);
    check("mul_ovf", int'(ovf), 0);
    @(negedge clk);
    check("mul_valid_one_cycle", int'(result_valid), 0);
    check("mul_busy_done", int'(busy), 0);

    // 2 ^ 7 from S_DONE
    press_seq(4'h2, 4'hE, 4'h7, 4'hF);
    wait_result(40, lat, bc);
    check("pow27_latency", lat, 8);
    check("pow27_busy_cycles", bc, 8);
    check("pow27_result", int'(result), 128);
    check("pow27_ovf", int'(ovf), 0);
    @(negedge clk);
    check("pow27_valid_one_cycle", int'(result_valid), 0);

    // 3 ^ 6 with keys injected while busy
    press_seq(4'h3, 4'hE, 4'h6, 4'hF);
    press(4'h5);
    press(4'hA);
    press(4'hF);
    wait_result(40, lat, bc);
    check("pow36_seen", int'(lat != -1), 1);
    check("pow36_result", int'(result), 217);
    check("pow36_ovf", int'(ovf), 1);

    // 5 / 0 then 2 - 7
    press_seq(4'h5, 4'hC, 4'h0, 4'hF);
    wait_result(20, lat, bc);
    check("div0_result", int'(result), 255);
    check("div0_err", int'(err), 1);
    check("div0_ovf", int'(ovf), 0);
    press_seq(4'h2, 4'hB, 4'h7, 4'hF);
    wait_result(20, lat, bc);
    check("sub_result", int'(result), 251);
    check("sub_ovf", int'(ovf), 1);
    check("sub_err", int'(err), 0);
    press(4'hF);
    check("clear_op_display", int'(op_display), 0);

    // 0 ^ 0 = 1, single busy cycle
    press_seq(4'h0, 4'hE, 4'h0, 4'hF);
    wait_result(20, lat, bc);
    check("pow00_latency", lat, 1);
    check("pow00_result", int'(result), 1);
    check("pow00_ovf", int'(ovf), 0);

    // Equals without a B digit is ignored, then 4 + 5
    press(4'h4);
    press(4'hA);
    press(4'hF);
    check("eq_no_b_ignored", int'(busy), 0);
    press(4'h5);
    press(4'hF);
    wait_result(20, lat, bc);
    check("add_result", int'(result), 9);
    check("add_ovf", int'(ovf), 0);

    // 9 ^ 9 aborted by reset three cycles into S_CALC
    press_seq(4'h9, 4'hE, 4'h9, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_result", int'(result), 0);
    check("abort_outputs", {result_valid, busy, ovf, err, op_display}, 0);
    @(negedge clk);
    reset = 1'b0;
    watch_quiet(15, seen);
    check("abort_no_valid", seen, 0);
    press(4'hF);
    check("abort_in_s_a", int'(busy), 0);
    press_seq(4'h1, 4'hA, 4'h1, 4'hF);
    wait_result(20, lat, bc);
    check("post_abort_result", int'(result), 2);

    // Chaining from S_DONE
    press_seq(4'h3, 4'hD, 4'h4, 4'hF);
    wait_result(20, lat, bc);
    check("chain_first", int'(result), 12);
    press(4'hA);
    press(4'h5);
    press(4'hF);
`ifdef CALC_CHAIN_EN
    wait_result(20, lat, bc);
    check("chain_result", int'(result), 17);
`else
    watch_quiet(5, seen);
    check("nochain_no_valid", seen, 0);
    check("nochain_result_held", int'(result), 12);
    press(4'hF);
    check("nochain_in_s_a", int'(busy), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
